fifo_wr_arbiter: RTL

//  Write-side arbiter for the async FIFO: shares one FIFO write port (winc/wdata) among NREQ requesters.

---
 rtl/fifo_wr_arbiter_pkg.sv | 16 +
 rtl/fifo_wr_arbiter_if.sv | 36 +++
 rtl/fifo_wr_arbiter_rr_picker.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the async-FIFO write-side arbiter.
// Provides the FSM state enum, the stats counter width and a modulo increment.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  localparam int STAT_W = 16;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO bundle for the write arbiter.
// slave: arbiter side (takes req_*, FIFO flags; drives ready/winc/wdata/gnt_*).
// master: the environment side (requesters plus FIFO write port).
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
) ();

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][DSIZE-1:0] req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       winc;
  logic [DSIZE-1:0]           wdata;
  logic                       wfull;
  logic                       whalf_full;
  logic                       wthree_quarters_full;
  logic                       gnt_valid;
  logic [IW-1:0]              gnt_id;

  modport slave (
    input  req_valid, req_data,
    input  wfull, whalf_full, wthree_quarters_full,
    output req_ready, winc, wdata,
    output gnt_valid, gnt_id
  );

  modport master (
    output req_valid, req_data,
    output wfull, whalf_full, wthree_quarters_full,
    input  req_ready, winc, wdata,
    input  gnt_valid, gnt_id
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: first eligible index at or after rr_ptr, wrapping.
// Ports: eligible mask, rr_ptr in; found, idx out. Purely combinational.
module rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         eligible,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  function automatic logic [IW-1:0] slot(
    input logic [IW-1:0] p,
    input int            k
  );
    int j;
    j = int'(p) + k;
    if (j >= NREQ) j = j - NREQ;
    return IW'(j);
  endfunction

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (eligible[slot(rr_ptr, k)]) begin
        found = 1'b1;
        idx   = slot(rr_ptr, k);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter sharing one async-FIFO write port among NREQ requesters.
// Round-robin bursts, shortened at half-full, low-priority fenced at 3/4-full.
// Ports: wclk, wrst_n (async, active low), bus (fifo_wr_arbiter_if.slave).
// Optional macro FIFO_WR_ARB_STATS_EN adds stat_xfer_cnt / stat_throttle_cnt.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int              NREQ      = 4,
  parameter int              DSIZE     = 8,
  parameter int              BURST_MAX = 4,
  parameter logic [NREQ-1:0] HP_MASK   = {{(NREQ-1){1'b0}}, 1'b1}
) (
  input logic             wclk,
  input logic             wrst_n,
  fifo_wr_arbiter_if.slave bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NREQ-1:0][STAT_W-1:0] stat_xfer_cnt,
  output logic [STAT_W-1:0]           stat_throttle_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;

  logic [NREQ-1:0] eligible;
  logic            found;
  logic [IW-1:0]   pick_idx;
  logic            own_valid;
  logic            own_elig;
  logic            xfer;
  logic [7:0]      lim;
  logic [8:0]      beat_nxt;

  // High-priority requesters ignore the 3/4 fence.
  assign eligible = bus.req_valid
                  & (HP_MASK | {NREQ{~bus.wthree_quarters_full}});

  rr_picker #(
    .NREQ(NREQ)
  ) u_pick (
    .eligible(eligible),
    .rr_ptr  (rr_ptr_q),
    .found   (found),
    .idx     (pick_idx)
  );

  assign own_valid = bus.req_valid[owner_q];
  assign own_elig  = eligible[owner_q];
  assign xfer      = (state_q == ARB_GRANT) & own_elig & ~bus.wfull;
  assign lim       = bus.whalf_full ? 8'(BURST_MAX / 2)
                                    : 8'(BURST_MAX);
  assign beat_nxt  = {1'b0, beat_cnt_q} + 9'd1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (xfer) beat_cnt_d = beat_nxt[7:0];
        // >= so a mid-burst drop of lim ends on the next beat.
        if ((xfer && (beat_nxt >= {1'b0, lim}))
            || !own_valid || !own_elig) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = IW'(rr_next(int'(owner_q), NREQ));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.winc      = xfer;
  assign bus.req_ready = NREQ'(xfer) << owner_q;
  assign bus.wdata     = bus.req_data[owner_q];
  assign bus.gnt_valid = (state_q == ARB_GRANT);
  assign bus.gnt_id    = owner_q;

`ifdef FIFO_WR_ARB_STATS_EN
  logic throttled_any;

  assign throttled_any = |(bus.req_valid & ~eligible);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stat_xfer_cnt     <= '0;
      stat_throttle_cnt <= '0;
    end else begin
      if (xfer && (stat_xfer_cnt[owner_q] != '1))
        stat_xfer_cnt[owner_q] <= stat_xfer_cnt[owner_q] + 1'b1;
      if (throttled_any && (stat_throttle_cnt != '1))
        stat_throttle_cnt <= stat_throttle_cnt + 1'b1;
    end
  end
`endif

endmodule
